mul_div_sched: RTL and testbench
================================

# mul_div_sched

Issue scheduler and two-port round-robin arbiter in front of the pipelined single-precision `mul_div` unit. Two requesters share the unit through valid/ready handshakes. The scheduler keeps the unit's `sel` stable while operations are in flight and inserts drains when the operation type changes. It tracks in-flight operations with a latency shift register and returns each registered result, with its flags, tagged by requester id.

## Interface
- `MUL_LAT`, default 4: cycles from operands driven on `ud_a/ud_b` to valid `ud_r` for a multiply.
- `DIV_LAT`, default 26: the same latency for a divide. Must be ≥ `MUL_LAT`.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `req0_valid  in  1`, `req0_ready  out  1`, `req0_op  in  1` (0=mul, 1=div), `req0_a  in  32`, `req0_b  in  32`: requester 0.
- `req1_valid  in  1`, `req1_ready  out  1`, `req1_op  in  1`, `req1_a  in  32`, `req1_b  in  32`: requester 1.
- `ud_a  out  32`, `ud_b  out  32`, `ud_sel  out  1`, `ud_en  out  1`: drive the `mul_div` inputs.
- `ud_r  in  32`, `ud_flags  in  5`: unit result and flags `{io,dz,of,uf,i}`.
- `rsp_valid  out  1`, `rsp_id  out  1`, `rsp_op  out  1`, `rsp_r  out  32`, `rsp_flags  out  5`: response. There is no backpressure.
- `busy  out  1`: high while any operation is in flight.

## Operation
- **Handshake.** A transfer occurs on a rising edge where `reqN_valid && reqN_ready`. Each `reqN_ready` is combinational from the valids and the scheduler state. At most one ready is high per cycle. Requesters hold `valid`, `op`, `a` and `b` stable until accepted.
- **Eligibility.** A request is eligible when `inflight==0`, or when `op==cur_op` and no drain is pending.
- **Arbitration.**
  - Round-robin pointer `rr`, reset to 0. When both requests are eligible, grant `rr`. On every grant, `rr` becomes the other id.
  - When only one request is eligible, grant it, unless a drain is pending.
- **Drain.**
  - The drain sets when the favored requester `rr` is valid, has `op!=cur_op`, and `inflight!=0`.
  - While the drain is set, no grants are given.
  - The drain clears when `inflight` reaches 0. The favored requester is then granted, so neither requester starves.
- **Issue.**
  - On a grant, register `ud_a`, `ud_b` and `cur_op` from the winner.
  - `ud_sel=cur_op`, and it changes only on a grant edge. `ud_en=1` except in reset.
  - Push `{valid,id,op}` into the tracker so that it emerges `lat+1` edges after the handshake edge (`lat` = `MUL_LAT` or `DIV_LAT`).
- **Retire.** When the tracker output is valid, register `rsp_r<=ud_r`, `rsp_flags<=ud_flags`, `rsp_id`, `rsp_op`, and set `rsp_valid<=1` for one cycle.
- **In-flight count.** `inflight` counts 0..`DIV_LAT`+1. It is incremented on a grant and decremented on a retire; both in one cycle leaves it unchanged. `busy=(inflight!=0)`.
- **Same-edge op switch.** A grant of a different op may occur on the same edge as the last retire, because the result is captured on that edge before `ud_sel` changes.

## Timing
- Reset values: `req*_ready=0` during reset; `ud_a=ud_b=0`; `ud_sel=0`; `ud_en=0`; all `rsp_*=0`; `busy=0`; `rr=0`; drain clear; tracker empty.
- Response latency: handshake at edge t gives `rsp_valid` high in the cycle after edge t+`lat`+1.
- Throughput: one issue per cycle with back-to-back same-op requests.
- Op switch penalty: the drain lasts until `inflight==0`.
- Reset mid-operation: the tracker is flushed, and no response is produced for operations in flight.
- Simultaneous valids with different ops while idle: `rr` wins, and the other request waits for the drain.

## Configuration
- `MUL_DIV_SCHED_PERF_EN` defined:
  - Adds `perf_issued out 32`, incremented on each grant.
  - Adds `perf_drain out 32`, incremented on each cycle with the drain set.
  - Both are 0 on reset and saturate at `32'hFFFF_FFFF`.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package `mul_div_sched_pkg` holds:
  - `op_e` enum (`OP_MUL=1'b0`, `OP_DIV=1'b1`);
  - `trk_entry_t` struct `{logic v; logic id; op_e op;}`;
  - `FLAGS_W=5`.
- Sub-module `rr_arb2`: two-input round-robin arbiter with eligibility and hold inputs. Outputs are the one-hot grant and the pointer update.

## Test plan
- **Single mul.** req0 mul `a=0x40000000` (2.0), `b=0x40400000` (3.0) → one `rsp_valid` 5 cycles after handshake with `id=0`, `r=0x40C00000`, `flags=0`.
- **Single div.** req1 div `0x40C00000`/`0x40000000` → `rsp_valid` 27 cycles after handshake with `id=1`, `r=0x40400000`.
- **Back-to-back muls.** Both requesters stream 8 muls each → grants alternate 0,1,0,1…; 16 responses in issue order, one per cycle; `busy` falls after the last one.
- **Op switch.** req0 mul streaming; req1 div asserted while `rr=1` → no grants until `inflight==0`, then req1 granted; `ud_sel` stays 0 until that grant edge; with `PERF_EN` defined, `perf_drain` equals the stall cycles.
- **Reset mid-operation.** Assert `rst` for 1 cycle 2 cycles after a div issue → no `rsp_valid` afterwards; all outputs at their reset values; next mul completes normally.
- **Divide by zero.** `b=0x00000000` div → response carries `ud_flags` unchanged (dz bit set) with correct `id`.

Source files
------------

// File: rtl/mul_div_sched_pkg.sv
// Shared types for the mul_div issue scheduler: op encoding, tracker entry, flag width.
package mul_div_sched_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef struct packed {
    logic v;
    logic id;
    op_e  op;
  } trk_entry_t;

  localparam int FLAGS_W = 5;

endpackage

// File: rtl/mul_div_sched_if.sv
// Requester channel: valid/ready handshake carrying one mul_div operation.
interface mul_div_sched_if;
  import mul_div_sched_pkg::*;

  logic        valid;
  logic        ready;
  op_e         op;
  logic [31:0] a;
  logic [31:0] b;

  modport master (output valid, op, a, b, input ready);
  modport slave  (input valid, op, a, b, output ready);

endinterface

// File: rtl/mul_div_sched_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational; hold suppresses all grants.
// Grants the pointer when both are eligible, otherwise the single eligible input.
module rr_arb2 (
  input  logic [1:0] elig,
  input  logic       hold,
  input  logic       rr,
  output logic [1:0] gnt,
  output logic       rr_nxt
);

  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      if (elig[0] && elig[1]) gnt[rr] = 1'b1;
      else                    gnt     = elig;
    end
    rr_nxt = rr;
    // Pointer moves to whichever requester did not win.
    if (|gnt) rr_nxt = gnt[0];
  end

endmodule

// File: rtl/mul_div_sched.sv
// Issue scheduler for the mul_div unit; response MUL_LAT/DIV_LAT+1 edges after handshake,
// no response backpressure, ready withheld during op-switch drains. Option: MUL_DIV_SCHED_PERF_EN.
module mul_div_sched
  import mul_div_sched_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 26
) (
  input  logic               clk,
  input  logic               rst,
  mul_div_sched_if.slave     req0,
  mul_div_sched_if.slave     req1,
  output logic [31:0]        ud_a,
  output logic [31:0]        ud_b,
  output logic               ud_sel,
  output logic               ud_en,
  input  logic [31:0]        ud_r,
  input  logic [FLAGS_W-1:0] ud_flags,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic               rsp_op,
  output logic [31:0]        rsp_r,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic               busy
`ifdef MUL_DIV_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_drain
`endif
);

  localparam int CNT_W = $clog2(DIV_LAT + 2);
  localparam int POS_W = $clog2(DIV_LAT + 1);

  typedef enum logic {S_RUN, S_DRAIN} drain_e;

  drain_e           state, state_nxt;
  op_e              cur_op, win_op, rr_op;
  logic             rr, rr_nxt, rr_vld, retire, empty, drain_cond, hold, granted, win_id;
  logic [1:0]       elig, arb_gnt, gnt;
  logic [CNT_W-1:0] inflight;
  logic [POS_W-1:0] win_pos;
  logic [31:0]      win_a, win_b;
  trk_entry_t       new_ent;
  trk_entry_t       trk [DIV_LAT+1];

  // "empty" means nothing remains in flight after this edge, so the last retire
  // and a grant of the other op can share an edge.
  assign retire     = trk[0].v;
  assign empty      = (inflight == CNT_W'(retire));
  assign rr_vld     = rr ? req1.valid : req0.valid;
  assign rr_op      = rr ? req1.op    : req0.op;
  assign drain_cond = rr_vld && (rr_op != cur_op) && !empty;
  assign elig[0]    = req0.valid && (empty || (req0.op == cur_op));
  assign elig[1]    = req1.valid && (empty || (req1.op == cur_op));

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (drain_cond) state_nxt = S_DRAIN;
      S_DRAIN: if (empty)      state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    hold = (state == S_DRAIN) ? !empty : drain_cond;
  end

  rr_arb2 u_arb (
    .elig   (elig),
    .hold   (hold),
    .rr     (rr),
    .gnt    (arb_gnt),
    .rr_nxt (rr_nxt)
  );

  assign gnt        = rst ? 2'b00 : arb_gnt;
  assign req0.ready = gnt[0];
  assign req1.ready = gnt[1];
  assign granted    = |gnt;
  assign win_id     = gnt[1];
  assign win_op     = gnt[1] ? req1.op : req0.op;
  assign win_a      = gnt[1] ? req1.a  : req0.a;
  assign win_b      = gnt[1] ? req1.b  : req0.b;
  assign win_pos    = (win_op == OP_DIV) ? POS_W'(DIV_LAT) : POS_W'(MUL_LAT);
  assign new_ent    = '{v: 1'b1, id: win_id, op: win_op};
  assign ud_sel     = cur_op;
  assign busy       = (inflight != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr       <= 1'b0;
      cur_op   <= OP_MUL;
      ud_a     <= '0;
      ud_b     <= '0;
      ud_en    <= 1'b0;
      inflight <= '0;
    end else begin
      ud_en <= 1'b1;
      rr    <= rr_nxt;
      if (granted) begin
        ud_a   <= win_a;
        ud_b   <= win_b;
        cur_op <= win_op;
      end
      if (granted && !retire)      inflight <= inflight + 1'b1;
      else if (!granted && retire) inflight <= inflight - 1'b1;
    end
  end

  // Entry written at depth lat reaches slot 0 after lat shifts and retires one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DIV_LAT; i++) trk[i] <= '0;
    end else begin
      for (int i = 0; i < DIV_LAT; i++) trk[i] <= trk[i+1];
      trk[DIV_LAT] <= '0;
      if (granted) trk[win_pos] <= new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_op    <= 1'b0;
      rsp_r     <= '0;
      rsp_flags <= '0;
    end else begin
      rsp_valid <= retire;
      if (retire) begin
        rsp_id    <= trk[0].id;
        rsp_op    <= trk[0].op;
        rsp_r     <= ud_r;
        rsp_flags <= ud_flags;
      end
    end
  end

`ifdef MUL_DIV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_drain  <= '0;
    end else begin
      if (granted && (perf_issued != 32'hFFFF_FFFF)) perf_issued <= perf_issued + 1'b1;
      if (hold && (perf_drain != 32'hFFFF_FFFF))     perf_drain  <= perf_drain + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_div_sched.sv
// Directed bench for mul_div_sched with a behavioural pipelined mul_div unit model.
module tb_mul_div_sched;
  import mul_div_sched_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 26;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_sched_if r0 ();
  mul_div_sched_if r1 ();

  logic [31:0] ud_a, ud_b, ud_r, rsp_r;
  logic        ud_sel, ud_en, rsp_valid, rsp_id, rsp_op, busy;
  logic [4:0]  ud_flags, rsp_flags;

  mul_div_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1),
    .ud_a(ud_a), .ud_b(ud_b), .ud_sel(ud_sel), .ud_en(ud_en),
    .ud_r(ud_r), .ud_flags(ud_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op(rsp_op),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Unit model: known IEEE vectors, divide-by-zero, otherwise a+b / a-b stand-ins.
  function automatic logic [36:0] unit_fn(input logic div, input logic [63:0] ab);
    logic [31:0] a, b;
    a = ab[63:32];
    b = ab[31:0];
    if (!div && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 5'b00000};
    if (div && a == 32'h40C00000 && b == 32'h40000000)  return {32'h40400000, 5'b00000};
    if (div && b == 32'h0)                              return {32'h7F800000, 5'b01000};
    return {div ? a - b : a + b, 5'b00000};
  endfunction

  logic [63:0] mul_pipe [MUL_LAT];
  logic [63:0] div_pipe [DIV_LAT];
  always @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) mul_pipe[i] <= mul_pipe[i-1];
    for (int i = DIV_LAT - 1; i > 0; i--) div_pipe[i] <= div_pipe[i-1];
    mul_pipe[0] <= {ud_a, ud_b};
    div_pipe[0] <= {ud_a, ud_b};
  end
  always_comb {ud_r, ud_flags} = unit_fn(ud_sel, ud_sel ? div_pipe[DIV_LAT-1] : mul_pipe[MUL_LAT-1]);

  typedef struct {int cyc; logic id; logic op; logic [31:0] r; logic [4:0] flags; logic busy;} rsp_t;
  typedef struct {int cyc; logic id; logic op; logic [31:0] a; logic [31:0] b;} hs_t;
  rsp_t rsp_q[$];
  hs_t  hs_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic acc0, acc1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rsp_t e;
    hs_t  h;
    if (rsp_valid === 1'b1) begin
      e.cyc = cyc; e.id = rsp_id; e.op = rsp_op; e.r = rsp_r; e.flags = rsp_flags; e.busy = busy;
      rsp_q.push_back(e);
    end
    if (r0.valid && r0.ready === 1'b1) begin
      h.cyc = cyc + 1; h.id = 1'b0; h.op = r0.op; h.a = r0.a; h.b = r0.b;
      hs_q.push_back(h);
    end
    if (r1.valid && r1.ready === 1'b1) begin
      h.cyc = cyc + 1; h.id = 1'b1; h.op = r1.op; h.a = r1.a; h.b = r1.b;
      hs_q.push_back(h);
    end
  end

  function automatic rsp_t rsp_at(input int i);
    rsp_t e = '{default: 0};
    if (i < rsp_q.size()) e = rsp_q[i];
    return e;
  endfunction

  function automatic hs_t hs_at(input int i);
    hs_t h = '{default: 0};
    if (i < hs_q.size()) h = hs_q[i];
    return h;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc0 = r0.valid && (r0.ready === 1'b1);
    acc1 = r1.valid && (r1.ready === 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input logic id, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(id ? acc1 : acc0) && n < budget);
    check(id ? "accept1" : "accept0", id ? acc1 : acc0, 1'b1);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("rsp_count", rsp_q.size(), n);
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    hs_q.delete();
  endtask

  initial begin
    int   i0, i1, n;
    logic sel_early;

    rst = 1'b1;
    r0.valid = 1'b0; r0.op = OP_MUL; r0.a = '0; r0.b = '0;
    r1.valid = 1'b0; r1.op = OP_MUL; r1.a = '0; r1.b = '0;
    @(posedge clk); #1;
    r0.valid = 1'b1;
    r1.valid = 1'b1;
    tick();
    tick();
    check("rst_ready0", r0.ready, 1'b0);
    check("rst_ready1", r1.ready, 1'b0);
    check("rst_ud_a", ud_a, 32'h0);
    check("rst_ud_sel", ud_sel, 1'b0);
    check("rst_ud_en", ud_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    rst = 1'b0;
    tick();
    check("ud_en_run", ud_en, 1'b1);

    // Single mul 2.0*3.0 from requester 0.
    clear_logs();
    r0.op = OP_MUL; r0.a = 32'h40000000; r0.b = 32'h40400000; r0.valid = 1'b1;
    wait_acc(1'b0, 10);
    r0.valid = 1'b0;
    check("mul_busy", busy, 1'b1);
    check("mul_ud_a", ud_a, 32'h40000000);
    check("mul_ud_sel", ud_sel, 1'b0);
    wait_rsp(1, 20);
    check("mul_lat", rsp_at(0).cyc - hs_at(0).cyc, 5);
    check("mul_id", rsp_at(0).id, 1'b0);
    check("mul_r", rsp_at(0).r, 32'h40C00000);
    check("mul_flags", rsp_at(0).flags, 5'b00000);
    repeat (10) tick();
    check("mul_one_rsp", rsp_q.size(), 1);

    // Single div 6.0/2.0 from requester 1.
    clear_logs();
    r1.op = OP_DIV; r1.a = 32'h40C00000; r1.b = 32'h40000000; r1.valid = 1'b1;
    wait_acc(1'b1, 10);
    r1.valid = 1'b0;
    check("div_ud_sel", ud_sel, 1'b1);
    wait_rsp(1, 40);
    check("div_lat", rsp_at(0).cyc - hs_at(0).cyc, 27);
    check("div_id", rsp_at(0).id, 1'b1);
    check("div_op", rsp_at(0).op, 1'b1);
    check("div_r", rsp_at(0).r, 32'h40400000);

    // Both requesters stream 8 muls each.
    clear_logs();
    i0 = 0; i1 = 0; n = 0;
    r0.op = OP_MUL; r0.a = 32'h10000000; r0.b = 32'h0; r0.valid = 1'b1;
    r1.op = OP_MUL; r1.a = 32'h20000000; r1.b = 32'h0; r1.valid = 1'b1;
    while ((i0 < 8 || i1 < 8) && n < 40) begin
      tick();
      n++;
      if (acc0) begin
        i0++;
        r0.a = 32'h10000000 + i0; r0.b = i0 << 8;
        if (i0 == 8) r0.valid = 1'b0;
      end
      if (acc1) begin
        i1++;
        r1.a = 32'h20000000 + i1; r1.b = i1 << 12;
        if (i1 == 8) r1.valid = 1'b0;
      end
    end
    check("stream_hs_count", hs_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check("stream_grant_id", hs_at(i).id, i % 2);
      check("stream_grant_cyc", hs_at(i).cyc, hs_at(0).cyc + i);
    end
    wait_rsp(16, 30);
    for (int i = 0; i < 16; i++) begin
      check("stream_rsp_id", rsp_at(i).id, i % 2);
      check("stream_rsp_r", rsp_at(i).r, hs_at(i).a + hs_at(i).b);
      check("stream_rsp_cyc", rsp_at(i).cyc, hs_at(i).cyc + 5);
    end
    check("stream_busy_prev", rsp_at(14).busy, 1'b1);
    check("stream_busy_last", rsp_at(15).busy, 1'b0);

    // Op switch: req1 div arrives while rr points at requester 1.
    clear_logs();
    r0.op = OP_MUL; r0.a = 32'h40000000; r0.b = 32'h40400000; r0.valid = 1'b1;
    wait_acc(1'b0, 10);
    r1.op = OP_DIV; r1.a = 32'h40C00000; r1.b = 32'h40000000; r1.valid = 1'b1;
    sel_early = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (!acc1) sel_early = sel_early | ud_sel;
    end while (!acc1 && n < 40);
    r1.valid = 1'b0;
    check("switch_accept1", acc1, 1'b1);
    check("switch_sel_early", sel_early, 1'b0);
    check("switch_sel_after", ud_sel, 1'b1);
    check("switch_hs_count", hs_q.size(), 2);
    check("switch_grant_id", hs_at(1).id, 1'b1);
    check("switch_grant_gap", hs_at(1).cyc - hs_at(0).cyc, 5);
    wait_acc(1'b0, 40);
    r0.valid = 1'b0;
    check("switch_back_gap", hs_at(2).cyc - hs_at(1).cyc, 27);
    wait_rsp(3, 60);
    check("switch_rsp0_r", rsp_at(0).r, 32'h40C00000);
    check("switch_rsp0_cyc", rsp_at(0).cyc, hs_at(0).cyc + 5);
    check("switch_rsp1_id", rsp_at(1).id, 1'b1);
    check("switch_rsp1_r", rsp_at(1).r, 32'h40400000);
    check("switch_rsp2_id", rsp_at(2).id, 1'b0);
    check("switch_rsp2_op", rsp_at(2).op, 1'b0);

    // Reset two cycles after a div issue.
    clear_logs();
    r1.op = OP_DIV; r1.a = 32'h40C00000; r1.b = 32'h40000000; r1.valid = 1'b1;
    wait_acc(1'b1, 10);
    r1.valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    r0.op = OP_MUL; r0.a = 32'h40000000; r0.b = 32'h40400000; r0.valid = 1'b1;
    tick();
    check("mid_rst_ready0", r0.ready, 1'b0);
    check("mid_rst_ud_a", ud_a, 32'h0);
    check("mid_rst_ud_b", ud_b, 32'h0);
    check("mid_rst_ud_sel", ud_sel, 1'b0);
    check("mid_rst_ud_en", ud_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_rsp_r", rsp_r, 32'h0);
    check("mid_rst_rsp_id", rsp_id, 1'b0);
    rst = 1'b0;
    clear_logs();
    wait_acc(1'b0, 10);
    r0.valid = 1'b0;
    wait_rsp(1, 20);
    repeat (35) tick();
    check("mid_rst_no_stale", rsp_q.size(), 1);
    check("mid_rst_mul_id", rsp_at(0).id, 1'b0);
    check("mid_rst_mul_r", rsp_at(0).r, 32'h40C00000);
    check("mid_rst_mul_lat", rsp_at(0).cyc - hs_at(0).cyc, 5);

    // Divide by zero passes dz flag through.
    clear_logs();
    r0.op = OP_DIV; r0.a = 32'h3F800000; r0.b = 32'h0; r0.valid = 1'b1;
    wait_acc(1'b0, 10);
    r0.valid = 1'b0;
    wait_rsp(1, 40);
    check("dz_id", rsp_at(0).id, 1'b0);
    check("dz_op", rsp_at(0).op, 1'b1);
    check("dz_flags", rsp_at(0).flags, 5'b01000);
    check("dz_r", rsp_at(0).r, 32'h7F800000);
    check("dz_lat", rsp_at(0).cyc - hs_at(0).cyc, 27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
